// File: rtl/nonce_scan_pkg.sv
// Shared types and constants for the nonce scanner: FSM states, summary-word
// layout and the memory read latency.
package nonce_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int FOUND_BIT   = 31;
  localparam int SUM_IDX_MSB = 7;
  localparam int SUM_IDX_LSB = 0;
  localparam int MEM_RD_LAT  = 2;

endpackage

// File: rtl/hash_min_tracker.sv
// Compares each captured hash word against the target and keeps the first
// passing word plus the running strict minimum (ties keep the lower index).
module hash_min_tracker
  import nonce_scan_pkg::*;
#(
  parameter int NUM_WORDS = 16,
  parameter int IDX_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             cap,
  input  logic [31:0]      word,
  input  logic [31:0]      target,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic [31:0]      hash,
  output logic             all_captured
);

  localparam int CW = $clog2(NUM_WORDS + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             any_pass_q, any_pass_d;
  logic [IDX_W-1:0] fp_idx_q, fp_idx_d;
  logic [31:0]      fp_hash_q, fp_hash_d;
  logic [IDX_W-1:0] min_idx_q, min_idx_d;
  logic [31:0]      min_hash_q, min_hash_d;
  logic [IDX_W-1:0] cur_idx;

  always_comb begin
    cnt_d      = cnt_q;
    any_pass_d = any_pass_q;
    fp_idx_d   = fp_idx_q;
    fp_hash_d  = fp_hash_q;
    min_idx_d  = min_idx_q;
    min_hash_d = min_hash_q;
    cur_idx    = IDX_W'(cnt_q);
    if (clear) begin
      cnt_d      = '0;
      any_pass_d = 1'b0;
      fp_idx_d   = '0;
      fp_hash_d  = '0;
      min_idx_d  = '0;
      min_hash_d = '0;
    end else if (cap) begin
      cnt_d = cnt_q + CW'(1);
      if (!any_pass_q && (word <= target)) begin
        any_pass_d = 1'b1;
        fp_idx_d   = cur_idx;
        fp_hash_d  = word;
      end
      // The first capture seeds the minimum so a cleared 0 never wins.
      if ((cnt_q == '0) || (word < min_hash_q)) begin
        min_idx_d  = cur_idx;
        min_hash_d = word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      any_pass_q <= 1'b0;
      fp_idx_q   <= '0;
      fp_hash_q  <= '0;
      min_idx_q  <= '0;
      min_hash_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      any_pass_q <= any_pass_d;
      fp_idx_q   <= fp_idx_d;
      fp_hash_q  <= fp_hash_d;
      min_idx_q  <= min_idx_d;
      min_hash_q <= min_hash_d;
    end
  end

  assign found        = any_pass_q;
  assign idx          = any_pass_q ? fp_idx_q : min_idx_q;
  assign hash         = any_pass_q ? fp_hash_q : min_hash_q;
  assign all_captured = (cnt_q == CW'(NUM_WORDS));

endmodule

// File: rtl/nonce_scanner.sv
// Scans NUM_WORDS hash words from memory and reports the first passing nonce or
// the minimum hash. Define NONCE_SCAN_WRITEBACK_EN to write a summary word back.
module nonce_scanner
  import nonce_scan_pkg::*;
#(
  parameter int NUM_WORDS = 16,
  parameter int IDX_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      result_addr,
  input  logic [31:0]      target,
  output logic             mem_clk,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] nonce_idx,
  output logic [31:0]      best_hash
);

  localparam int CW = $clog2(NUM_WORDS + 1);

  state_e                state_q, state_d;
  logic [15:0]           base_q, base_d;
  logic [31:0]           target_q, target_d;
  logic [15:0]           mem_addr_q, mem_addr_d;
  logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
  logic [MEM_RD_LAT-1:0] vld_q, vld_d;
  logic                  done_q, done_d;
  logic                  found_q, found_d;
  logic [IDX_W-1:0]      nonce_idx_q, nonce_idx_d;
  logic [31:0]           best_hash_q, best_hash_d;
  logic                  issue, clear;
  logic                  trk_found, trk_all;
  logic [IDX_W-1:0]      trk_idx;
  logic [31:0]           trk_hash;

`ifdef NONCE_SCAN_WRITEBACK_EN
  logic                  mem_we_q, mem_we_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [31:0]           summary;

  always_comb begin
    summary                          = '0;
    summary[FOUND_BIT]               = trk_found;
    summary[SUM_IDX_MSB:SUM_IDX_LSB] = 8'(trk_idx);
  end
`endif

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    target_d    = target_q;
    mem_addr_d  = mem_addr_q;
    issue_cnt_d = issue_cnt_q;
    done_d      = done_q;
    found_d     = found_q;
    nonce_idx_d = nonce_idx_q;
    best_hash_d = best_hash_q;
    issue       = 1'b0;
    clear       = 1'b0;
`ifdef NONCE_SCAN_WRITEBACK_EN
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clear       = 1'b1;
          issue       = 1'b1;
          base_d      = result_addr;
          target_d    = target;
          mem_addr_d  = result_addr;
          issue_cnt_d = CW'(1);
          done_d      = 1'b0;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        issue       = 1'b1;
        mem_addr_d  = base_q + 16'(issue_cnt_q);
        issue_cnt_d = issue_cnt_q + CW'(1);
        if (issue_cnt_q == CW'(NUM_WORDS - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (trk_all) begin
`ifdef NONCE_SCAN_WRITEBACK_EN
          mem_we_d    = 1'b1;
          mem_addr_d  = base_q + 16'(NUM_WORDS);
          mem_wdata_d = summary;
          state_d     = ST_WRITE;
`else
          found_d     = trk_found;
          nonce_idx_d = trk_idx;
          best_hash_d = trk_hash;
          done_d      = 1'b1;
          state_d     = ST_DONE;
`endif
        end
      end
      ST_WRITE: begin
        found_d     = trk_found;
        nonce_idx_d = trk_idx;
        best_hash_d = trk_hash;
        done_d      = 1'b1;
        state_d     = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Read-data valid shifts alongside the memory's fixed latency.
    vld_d = {vld_q[MEM_RD_LAT-2:0], issue};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      target_q    <= '0;
      mem_addr_q  <= '0;
      issue_cnt_q <= '0;
      vld_q       <= '0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      nonce_idx_q <= '0;
      best_hash_q <= '0;
`ifdef NONCE_SCAN_WRITEBACK_EN
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      target_q    <= target_d;
      mem_addr_q  <= mem_addr_d;
      issue_cnt_q <= issue_cnt_d;
      vld_q       <= vld_d;
      done_q      <= done_d;
      found_q     <= found_d;
      nonce_idx_q <= nonce_idx_d;
      best_hash_q <= best_hash_d;
`ifdef NONCE_SCAN_WRITEBACK_EN
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
`endif
    end
  end

  hash_min_tracker #(
    .NUM_WORDS(NUM_WORDS),
    .IDX_W    (IDX_W)
  ) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .cap         (vld_q[MEM_RD_LAT-1]),
    .word        (mem_read_data),
    .target      (target_q),
    .found       (trk_found),
    .idx         (trk_idx),
    .hash        (trk_hash),
    .all_captured(trk_all)
  );

  assign mem_clk   = clk;
  assign mem_addr  = mem_addr_q;
  assign done      = done_q;
  assign found     = found_q;
  assign nonce_idx = nonce_idx_q;
  assign best_hash = best_hash_q;
`ifdef NONCE_SCAN_WRITEBACK_EN
  assign mem_we         = mem_we_q;
  assign mem_write_data = mem_wdata_q;
`else
  assign mem_we         = 1'b0;
  assign mem_write_data = '0;
`endif

endmodule

// File: tb/tb_nonce_scanner.sv
// Randomized bench for nonce_scanner with a synchronous-read memory model and
// a first-pass / strict-minimum reference computed directly from the word list.
module tb_nonce_scanner;

  localparam int N = 16;
`ifdef NONCE_SCAN_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif
  localparam int DONE_EDGE = WB ? N + 3 : N + 2;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] result_addr;
  logic [31:0] target;
  logic        mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic        done, found;
  logic [7:0]  nonce_idx;
  logic [31:0] best_hash;

  nonce_scanner #(.NUM_WORDS(N), .IDX_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .result_addr(result_addr),
    .target(target), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .done(done), .found(found), .nonce_idx(nonce_idx), .best_hash(best_hash)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  always @(posedge clk) mem_read_data <= mem[mem_addr];

  int n_err = 0;
  int n_chk = 0;
  logic [31:0] words [N];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] base);
    for (int i = 0; i < N; i++) mem[base + 16'(i)] = words[i];
  endtask

  task automatic model(input logic [31:0] tgt, output logic f,
                       output logic [7:0] idx, output logic [31:0] h);
    f = 1'b0; idx = 8'd0; h = words[0];
    for (int i = 0; i < N; i++)
      if (!f && words[i] <= tgt) begin f = 1'b1; idx = 8'(i); h = words[i]; end
    if (!f)
      for (int i = 1; i < N; i++)
        if (words[i] < h) begin h = words[i]; idx = 8'(i); end
  endtask

  task automatic run_scan(input string nm, input logic [15:0] base,
                          input logic [31:0] tgt, input bit restart4);
    logic f; logic [7:0] idx; logic [31:0] h;
    int done_edge, addr_bad, wcnt, wedge;
    logic [15:0] waddr; logic [31:0] wdata;
    model(tgt, f, idx, h);
    load(base);
    done_edge = -1; addr_bad = 0; wcnt = 0; wedge = -1; waddr = '0; wdata = '0;
    @(negedge clk);
    start = 1'b1; result_addr = base; target = tgt;
    @(posedge clk); #1;
    start = 1'b0; result_addr = 16'($urandom); target = $urandom;
    chk({nm, "/done_fall"}, 32'(done), 32'd0);
    if (mem_addr !== base) addr_bad++;
    for (int e = 1; e <= 40 && done_edge < 0; e++) begin
      @(posedge clk); #1;
      if (restart4 && e == 3) start = 1'b1;
      if (restart4 && e == 4) start = 1'b0;
      if (e < N && mem_addr !== base + 16'(e)) addr_bad++;
      if (mem_we === 1'b1) begin wcnt++; wedge = e; waddr = mem_addr; wdata = mem_write_data; end
      if (done === 1'b1) done_edge = e;
    end
    chk({nm, "/done_edge"}, 32'(done_edge), 32'(DONE_EDGE));
    chk({nm, "/addr_seq"}, 32'(addr_bad), 32'd0);
    chk({nm, "/found"}, 32'(found), 32'(f));
    chk({nm, "/nonce_idx"}, 32'(nonce_idx), 32'(idx));
    chk({nm, "/best_hash"}, best_hash, h);
    if (WB) begin
      chk({nm, "/wr_count"}, 32'(wcnt), 32'd1);
      chk({nm, "/wr_edge"}, 32'(wedge), 32'(N + 2));
      chk({nm, "/wr_addr"}, 32'(waddr), 32'(base + 16'(N)));
      chk({nm, "/wr_data"}, wdata, {f, 23'd0, idx});
    end else begin
      chk({nm, "/wr_count"}, 32'(wcnt), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "/hold"}, {done, found, 22'd0, nonce_idx}, {1'b1, f, 22'd0, idx});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; result_addr = '0; target = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/outs", {done, found, 6'd0, nonce_idx, 16'd0}, 32'd0);
    chk("reset/hash", best_hash, 32'd0);
    chk("reset/mem", {mem_we, 15'd0, mem_addr}, 32'd0);
    chk("reset/wdata", mem_write_data, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < N; i++) words[i] = 32'h9000_0000 + 32'(i) * 32'h100;
    run_scan("ascend", 16'h0040, 32'h0000_FFFF, 1'b0);

    for (int i = 0; i < N; i++) words[i] = 32'hFFFF_FFFF;
    words[5] = 32'h0000_1234; words[11] = 32'h0000_0001;
    run_scan("first_pass", 16'h2000, 32'h0000_2000, 1'b0);

    for (int i = 0; i < N; i++) words[i] = 32'h8000_0000;
    run_scan("tie", 16'h3000, 32'h7FFF_FFFF, 1'b0);
    run_scan("all_pass", 16'h3000, 32'hFFFF_FFFF, 1'b0);

    for (int i = 0; i < N; i++) words[i] = 32'hFFFF_FFFF;
    words[3] = 32'h0000_0010; words[9] = 32'h0000_0002;
    run_scan("pass3", 16'h0100, 32'h0000_0100, 1'b0);
    run_scan("restart", 16'h0100, 32'h0000_0100, 1'b1);

    for (int k = 0; k < 10; k++) begin
      logic [15:0] b; logic [31:0] t;
      for (int i = 0; i < N; i++)
        words[i] = (k % 2 == 0) ? $urandom : {2'($urandom_range(0, 3)), 30'd0};
      b = (k == 3) ? 16'hFFF8 : 16'($urandom);
      t = (k % 3 == 0) ? 32'hFFFF_FFFF : (k % 3 == 1) ? $urandom : ($urandom >> 6);
      run_scan($sformatf("rand%0d", k), b, t, 1'b0);
    end

    // Reset in the middle of a scan, with nonzero results latched beforehand.
    for (int i = 0; i < N; i++) words[i] = 32'hFFFF_FFFF;
    words[7] = 32'h5;
    run_scan("pre_reset", 16'h4000, 32'h10, 1'b0);
    @(negedge clk);
    start = 1'b1; result_addr = 16'h5000; target = 32'h10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst/outs", {done, found, 6'd0, nonce_idx, 16'd0}, 32'd0);
    chk("midrst/hash", best_hash, 32'd0);
    chk("midrst/mem", {mem_we, 15'd0, mem_addr}, 32'd0);
    chk("midrst/wdata", mem_write_data, 32'd0);
    for (int i = 0; i < N; i++) words[i] = 32'h7000_0000 - 32'(i);
    run_scan("post_reset", 16'h6000, 32'h0000_0FFF, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
